// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell indices, row/column move codes and the
// keypad front-end state encoding.
package ttt_pkg;

   localparam int unsigned NUM_CELLS = 9;
   localparam int unsigned RC_W      = 2;
   localparam int unsigned GRID_DIM  = 3;

   // Cell index constants; cell k sits at row k/3+1, column k%3+1
   localparam int unsigned CELL_0 = 0;
   localparam int unsigned CELL_1 = 1;
   localparam int unsigned CELL_2 = 2;
   localparam int unsigned CELL_3 = 3;
   localparam int unsigned CELL_4 = 4;
   localparam int unsigned CELL_5 = 5;
   localparam int unsigned CELL_6 = 6;
   localparam int unsigned CELL_7 = 7;
   localparam int unsigned CELL_8 = 8;

   // Row/column move codes; RC_NONE means "no cell"
   localparam logic [RC_W-1:0] RC_NONE = 2'b00;
   localparam logic [RC_W-1:0] RC_1    = 2'b01;
   localparam logic [RC_W-1:0] RC_2    = 2'b10;
   localparam logic [RC_W-1:0] RC_3    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_OFFER    = 2'd2,
      ST_RELEASE  = 2'd3
   } state_e;

   // Map a 0-based row or column position to its 1-based move code
   function automatic logic [RC_W-1:0] rc_code(input int unsigned pos);
      return RC_W'(pos + 1);
   endfunction

endpackage

// File: rtl/cell_index_encoder.sv
// Combinational one-hot cell to row/column move code encoder.
// Ports:
//   key    in  9  cell vector, bit k = cell k
//   r      out 2  row code 01..11 for a one-hot key, 00 otherwise
//   c      out 2  column code 01..11 for a one-hot key, 00 otherwise
//   onehot out 1  key has exactly one bit set
module cell_index_encoder
   import ttt_pkg::*;
(
   input  logic [NUM_CELLS-1:0] key,
   output logic [RC_W-1:0]      r,
   output logic [RC_W-1:0]      c,
   output logic                 onehot
);

   // Exact match against each one-hot pattern, so any multi-bit or zero key yields 00/00
   always_comb begin
      r      = RC_NONE;
      c      = RC_NONE;
      onehot = 1'b0;
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
         if (key == (NUM_CELLS'(1) << k)) begin
            r      = rc_code(k / GRID_DIM);
            c      = rc_code(k % GRID_DIM);
            onehot = 1'b1;
         end
      end
   end

endmodule

// File: rtl/move_input_encoder.sv
// Debounced 3x3 keypad front end producing a row/column move over valid/ready.
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous active-high reset
//   key          in   9  raw keypad, bit k = cell k
//   occupied     in   9  board occupancy mask, same bit order as key
//   out_ready    in   1  consumer accepts the offered move
//   out_valid    out  1  move offered on r/c
//   r, c         out  2  row/column code, 00 when out_valid=0
//   err_multi    out  1  pulse: debounced press not one-hot
//   err_occupied out  1  pulse: debounced press on an occupied cell
//   busy         out  1  state is not IDLE
module move_input_encoder
   import ttt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CELLS-1:0] key,
   input  logic [NUM_CELLS-1:0] occupied,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [RC_W-1:0]      r,
   output logic [RC_W-1:0]      c,
   output logic                 err_multi,
   output logic                 err_occupied,
   output logic                 busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_CELLS-1:0]   key_q, key_d;
   logic                   valid_q, valid_d;
   logic [RC_W-1:0]        r_q, r_d;
   logic [RC_W-1:0]        c_q, c_d;
   logic                   err_multi_q, err_multi_d;
   logic                   err_occ_q, err_occ_d;
   logic                   busy_q, busy_d;

   logic [RC_W-1:0]        enc_r_c;
   logic [RC_W-1:0]        enc_c_c;
   logic                   enc_onehot_c;

   cell_index_encoder u_enc (
      .key    (key_q),
      .r      (enc_r_c),
      .c      (enc_c_c),
      .onehot (enc_onehot_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      valid_d     = valid_q;
      r_d         = r_q;
      c_d         = c_q;
      err_multi_d = 1'b0;
      err_occ_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (key != '0) begin
               key_d   = key;
               cnt_d   = CNT_ONE;
               state_d = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (key != key_q) begin
               if (key == '0) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  key_d = key;
                  cnt_d = CNT_ONE;
               end
            end else if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               // key_q stable for DEBOUNCE_CYCLES samples: evaluate in priority order
               cnt_d   = '0;
               state_d = ST_RELEASE;
               if (!enc_onehot_c) begin
                  err_multi_d = 1'b1;
               end else if ((key_q & occupied) != '0) begin
                  err_occ_d = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  r_d     = enc_r_c;
                  c_d     = enc_c_c;
                  state_d = ST_OFFER;
               end
            end
         end

         ST_OFFER: begin
            if (out_ready) begin
               valid_d = 1'b0;
               r_d     = RC_NONE;
               c_d     = RC_NONE;
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            // Counts consecutive all-released samples; any key activity restarts it
            if (key != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         key_q       <= '0;
         valid_q     <= 1'b0;
         r_q         <= RC_NONE;
         c_q         <= RC_NONE;
         err_multi_q <= 1'b0;
         err_occ_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         valid_q     <= valid_d;
         r_q         <= r_d;
         c_q         <= c_d;
         err_multi_q <= err_multi_d;
         err_occ_q   <= err_occ_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid    = valid_q;
   assign r            = r_q;
   assign c            = c_q;
   assign err_multi    = err_multi_q;
   assign err_occupied = err_occ_q;
   assign busy         = busy_q;

endmodule
